// File: rtl/secded_pkg.sv
// Shared types and the Hamming(8,4)+overall-parity encode function.
// The function is the single source of truth for the codeword layout and is
// reused by the decoder bench as its reference model.
//   codeword bits: [3:0] data, [4] p0, [5] p1, [6] p2, [7] overall parity
package secded_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] codeword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } tx_state_e;

  function automatic codeword_t hamming84_enc(input nibble_t d);
    codeword_t cw;
    cw[3:0] = d;
    cw[4]   = d[0] ^ d[1] ^ d[3];
    cw[5]   = d[0] ^ d[2] ^ d[3];
    cw[6]   = d[1] ^ d[2] ^ d[3];
    cw[7]   = ^cw[6:0];
    return cw;
  endfunction

endpackage

// File: rtl/secded_nibble_enc.sv
// Combinational nibble -> Hamming(8,4)+parity codeword encoder.
// Ports:
//   nib_i  in  4  data nibble
//   cw_o   out 8  codeword (no injection applied here)
module secded_nibble_enc
  import secded_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] cw_o
);

  assign cw_o = hamming84_enc(nibble_t'(nib_i));

endmodule

// File: rtl/secded_tx_encoder.sv
// Byte-to-codeword transmit stage. Each accepted byte is split into two
// nibbles (low first), each encoded into an 8-bit SECDED codeword, optionally
// XORed with a per-nibble injection mask latched with the byte.
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   in_valid/ready   byte input handshake; in_ready is combinational in HI
//   byte_in          data byte, [3:0] sent first
//   inj_lo/hi_mask   XOR masks for the low/high codewords, sampled on accept
//   out_valid/ready  codeword output handshake
//   enc_data         registered codeword
//   out_hi           0 = low-nibble codeword, 1 = high-nibble codeword
//   cw_count         wrapping count of transferred codewords
//
// state | meaning
// IDLE  | nothing held, ready for a byte
// LO    | low-nibble codeword presented
// HI    | high-nibble codeword presented; may accept the next byte
module secded_tx_encoder
  import secded_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       byte_in,
  input  logic [7:0]       inj_lo_mask,
  input  logic [7:0]       inj_hi_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       enc_data,
  output logic             out_hi,
  output logic [CNT_W-1:0] cw_count
);

  tx_state_e        state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       hi_mask_q, hi_mask_d;
  logic [7:0]       enc_q, enc_d;
  logic             out_hi_q, out_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] lo_mask_in, hi_mask_in;
  logic [3:0] nib_sel;
  logic [7:0] mask_sel;
  logic [7:0] cw;
  logic       accept;

  // With injection disabled the masks are tied off so the XOR folds away.
  generate
    if (INJ_EN) begin : g_inj
      assign lo_mask_in = inj_lo_mask;
      assign hi_mask_in = inj_hi_mask;
    end else begin : g_no_inj
      assign lo_mask_in = 8'h00;
      assign hi_mask_in = 8'h00;
    end
  endgenerate

  // Single encoder: in LO the held high nibble is next, otherwise the only
  // codeword that can be loaded is the low nibble of an incoming byte.
  assign nib_sel  = (state_q == LO) ? byte_q[7:4] : byte_in[3:0];
  assign mask_sel = (state_q == LO) ? hi_mask_q   : lo_mask_in;

  secded_nibble_enc u_enc (
    .nib_i (nib_sel),
    .cw_o  (cw)
  );

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    hi_mask_d = hi_mask_q;
    enc_d     = enc_q;
    out_hi_d  = out_hi_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      LO: begin
        out_valid = 1'b1;
        if (out_ready) begin
          enc_d    = cw ^ mask_sel;
          out_hi_d = 1'b1;
          state_d  = HI;
        end
      end
      HI: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          accept  = in_valid;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      byte_d    = byte_in;
      hi_mask_d = hi_mask_in;
      enc_d     = cw ^ mask_sel;
      out_hi_d  = 1'b0;
      state_d   = LO;
    end

    cnt_d = cnt_q + CNT_W'(out_valid & out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      byte_q    <= 8'h00;
      hi_mask_q <= 8'h00;
      enc_q     <= 8'h00;
      out_hi_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      hi_mask_q <= hi_mask_d;
      enc_q     <= enc_d;
      out_hi_q  <= out_hi_d;
      cnt_q     <= cnt_d;
    end
  end

  assign enc_data = enc_q;
  assign out_hi   = out_hi_q;
  assign cw_count = cnt_q;

endmodule

// File: tb/tb_secded_tx_encoder.sv
module tb_secded_tx_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  byte_in;
  logic [7:0]  inj_lo_mask;
  logic [7:0]  inj_hi_mask;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_hi;
  logic [7:0]  enc_data;
  logic [15:0] cw_count;

  logic        in_ready4, out_valid4, out_hi4;
  logic [7:0]  enc_data4;
  logic [3:0]  cw_count4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  secded_tx_encoder #(.CNT_W(16), .INJ_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .byte_in(byte_in), .inj_lo_mask(inj_lo_mask), .inj_hi_mask(inj_hi_mask),
    .out_valid(out_valid), .out_ready(out_ready), .enc_data(enc_data),
    .out_hi(out_hi), .cw_count(cw_count)
  );

  secded_tx_encoder #(.CNT_W(4), .INJ_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .byte_in(byte_in), .inj_lo_mask(inj_lo_mask), .inj_hi_mask(inj_hi_mask),
    .out_valid(out_valid4), .out_ready(out_ready), .enc_data(enc_data4),
    .out_hi(out_hi4), .cw_count(cw_count4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    byte_in     = 8'h00;
    inj_lo_mask = 8'h00;
    inj_hi_mask = 8'h00;
    rst_n       = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, out_hi, enc_data, cw_count} !== {1'b0, 1'b1, 1'b0, 8'h00, 16'h0000})
      $display("FAIL reset_values: ov=%b ir=%b hi=%b enc=%h cnt=%h, want 0 1 0 00 0000",
               out_valid, in_ready, out_hi, enc_data, cw_count);
    else passed++;
    in_valid = 1'b1;
    byte_in  = 8'h5A;
    step();
    total++;
    if ({out_valid, enc_data} !== {1'b0, 8'h00})
      $display("FAIL reset_no_accept: ov=%b enc=%h, want 0 00", out_valid, enc_data);
    else passed++;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    in_valid  = 1'b1;
    byte_in   = 8'h5A;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    byte_in  = 8'hxx;
    total++;
    if ({out_valid, in_ready, out_hi, enc_data} !== {1'b1, 1'b0, 1'b0, 8'hAA})
      $display("FAIL basic_lo: ov=%b ir=%b hi=%b enc=%h, want 1 0 0 AA",
               out_valid, in_ready, out_hi, enc_data);
    else passed++;
    step();
    total++;
    if ({out_valid, in_ready, out_hi, enc_data, cw_count} !== {1'b1, 1'b1, 1'b1, 8'h55, 16'd1})
      $display("FAIL basic_hi: ov=%b ir=%b hi=%b enc=%h cnt=%0d, want 1 1 1 55 1",
               out_valid, in_ready, out_hi, enc_data, cw_count);
    else passed++;
    step();
    total++;
    if ({out_valid, in_ready, enc_data, cw_count} !== {1'b0, 1'b1, 8'h55, 16'd2})
      $display("FAIL basic_idle: ov=%b ir=%b enc=%h cnt=%0d, want 0 1 55 2",
               out_valid, in_ready, enc_data, cw_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_enc [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    logic       exp_hi  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_ir  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    byte_in   = 8'h00;
    step();
    byte_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) in_valid = 1'b0;
      total++;
      if ({out_valid, out_hi, in_ready, enc_data} !== {1'b1, exp_hi[i], exp_ir[i], exp_enc[i]})
        $display("FAIL b2b_cycle%0d: ov=%b hi=%b ir=%b enc=%h, want 1 %b %b %h",
                 i, out_valid, out_hi, in_ready, enc_data, exp_hi[i], exp_ir[i], exp_enc[i]);
      else passed++;
      step();
    end
    total++;
    if ({out_valid, cw_count} !== {1'b0, 16'd4})
      $display("FAIL b2b_end: ov=%b cnt=%0d, want 0 4", out_valid, cw_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    in_valid = 1'b1;
    byte_in  = 8'h5A;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, out_hi, enc_data, cw_count} !== {1'b1, 1'b0, 1'b0, 8'hAA, 16'd0}) bad++;
      step();
    end
    total++;
    if (bad != 0)
      $display("FAIL bp_hold_lo: %0d of 5 cycles wrong, last ov=%b ir=%b enc=%h cnt=%0d, want 1 0 AA 0",
               bad, out_valid, in_ready, enc_data, cw_count);
    else passed++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    total++;
    if ({out_valid, out_hi, in_ready, enc_data, cw_count} !== {1'b1, 1'b1, 1'b0, 8'h55, 16'd1})
      $display("FAIL bp_release: ov=%b hi=%b ir=%b enc=%h cnt=%0d, want 1 1 0 55 1",
               out_valid, out_hi, in_ready, enc_data, cw_count);
    else passed++;
    step();
    total++;
    if ({out_valid, enc_data} !== {1'b1, 8'h55})
      $display("FAIL bp_hold_hi: ov=%b enc=%h, want 1 55", out_valid, enc_data);
    else passed++;
  endtask

  // Bench-side syndrome classification: 0 clean, 1 single, 2 double.
  function automatic int classify(input logic [7:0] c);
    logic s0, s1, s2, p;
    s0 = c[0] ^ c[1] ^ c[3] ^ c[4];
    s1 = c[0] ^ c[2] ^ c[3] ^ c[5];
    s2 = c[1] ^ c[2] ^ c[3] ^ c[6];
    p  = ^c;
    if (p) return 1;
    if ({s2, s1, s0} != 3'b000) return 2;
    return 0;
  endfunction

  task automatic test_inject();
    do_reset();
    in_valid    = 1'b1;
    byte_in     = 8'h5A;
    inj_lo_mask = 8'h01;
    inj_hi_mask = 8'h03;
    out_ready   = 1'b1;
    step();
    in_valid    = 1'b0;
    inj_lo_mask = 8'hxx;
    inj_hi_mask = 8'hxx;
    total++;
    if ({enc_data, out_hi} !== {8'hAB, 1'b0} || classify(enc_data) != 1)
      $display("FAIL inj_lo: enc=%h hi=%b class=%0d, want AB 0 1",
               enc_data, out_hi, classify(enc_data));
    else passed++;
    step();
    total++;
    if ({enc_data, out_hi} !== {8'h56, 1'b1} || classify(enc_data) != 2)
      $display("FAIL inj_hi: enc=%h hi=%b class=%0d, want 56 1 2",
               enc_data, out_hi, classify(enc_data));
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid  = 1'b1;
    byte_in   = 8'h5A;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, enc_data, out_hi, cw_count} !== {1'b0, 1'b1, 8'h00, 1'b0, 16'd0})
      $display("FAIL rst_mid: ov=%b ir=%b enc=%h hi=%b cnt=%0d, want 0 1 00 0 0",
               out_valid, in_ready, enc_data, out_hi, cw_count);
    else passed++;
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    byte_in   = 8'hFF;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_hi, enc_data, cw_count} !== {1'b1, 1'b0, 8'hFF, 16'd0})
      $display("FAIL rst_restart: ov=%b hi=%b enc=%h cnt=%0d, want 1 0 FF 0",
               out_valid, out_hi, enc_data, cw_count);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    byte_in   = 8'h3C;
    // 9 accepts land on edges 1,3,...,17; 18 transfers on edges 2..19.
    for (int e = 1; e <= 17; e++) step();
    in_valid = 1'b0;
    total++;
    if ({cw_count4, cw_count} !== {4'd0, 16'd16})
      $display("FAIL wrap_16: cnt4=%0d cnt16=%0d, want 0 16", cw_count4, cw_count);
    else passed++;
    step();
    step();
    total++;
    if ({cw_count4, cw_count, out_valid4} !== {4'd2, 16'd18, 1'b0})
      $display("FAIL wrap_18: cnt4=%0d cnt16=%0d ov4=%b, want 2 18 0",
               cw_count4, cw_count, out_valid4);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_inject();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
